// File: rtl/alu_pkg.sv
// Shared ALU datapath package: sub FSM states and datapath widths.
// Imported by the serial subtractor and its slice unit.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// master: producer+consumer side; slave: the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff,
    input  borrow, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff,
    output borrow, overflow
  );

endinterface

// File: rtl/serial_subtractor_slice.sv
// sub_slice: combinational SLICE-bit subtract with borrow.
// Ports: a, b, bin in; d = a-b-bin, bout = borrow out.
module sub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);

  logic [SLICE:0] r;

  // Zero-extended subtract: bit SLICE is set iff it wrapped.
  always_comb begin
    r = {1'b0, a} - {1'b0, b} - (SLICE+1)'(bin);
    d = r[SLICE-1:0];
    bout = r[SLICE];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Byte-serial a-b with borrow/overflow flags, LSB slice first.
// Ports: clk, rst (sync, active high), bus (slave handshake).
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SLICE = ALU_SLICE
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IW =
    (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(NSLICES - 1);

  sub_state_t       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE-1:0] s_a, s_b, s_d;
  logic             s_bout;

  assign s_a = a_q[idx_q*SLICE +: SLICE];
  assign s_b = b_q[idx_q*SLICE +: SLICE];

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .bin  (bin_q),
    .d    (s_d),
    .bout (s_bout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bin_d       = bin_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          idx_d      = '0;
          bin_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        diff_d[idx_q*SLICE +: SLICE] = s_d;
        bin_d = s_bout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          borrow_d = s_bout;
          // Top slice MSB is the result sign bit.
          ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                & (s_d[SLICE-1] ^ a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      bin_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bin_q       <= bin_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor.
// Drives/samples 1ns after each rising edge.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(32)) bus ();

  serial_subtractor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 1);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 0);
  endtask

  // Accept one operand pair, verify 4-cycle latency,
  // flags, and the handshake back to IDLE.
  task automatic run_op(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ed,
                        input logic eb,
                        input logic eo,
                        input int hold);
    int n;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".accept"}, 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = a ^ b ^ 32'h5a5a_a5a5;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".latency"}, n, 4);
    check({tag, ".diff"}, bus.diff, ed);
    check({tag, ".borrow"}, 32'(bus.borrow), 32'(eb));
    check({tag, ".ovf"}, 32'(bus.overflow), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_valid"},
            32'(bus.out_valid), 1);
      check({tag, ".hold_inrdy"},
            32'(bus.in_ready), 0);
      check({tag, ".hold_diff"}, bus.diff, ed);
      check({tag, ".hold_flags"},
            {30'd0, bus.borrow, bus.overflow},
            {30'd0, eb, eo});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_idle({tag, ".ret"});
  endtask

  initial begin : main
    int acc[2];
    int nacc;
    int nres;
    int seen;
    logic [31:0] res[2];
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;

    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset.diff", bus.diff, 0);
    check("reset.flags",
          {30'd0, bus.borrow, bus.overflow}, 0);

    run_op("t5m3", 32'h5, 32'h3, 32'h2, 0, 0, 0);
    run_op("t3m5", 32'h3, 32'h5,
           32'hffff_fffe, 1, 0, 0);
    run_op("tmin", 32'h8000_0000, 32'h1,
           32'h7fff_ffff, 0, 1, 0);
    run_op("ripple", 32'h0001_0000, 32'h1,
           32'h0000_ffff, 0, 0, 0);
    run_op("eq", 32'hdead_beef, 32'hdead_beef,
           32'h0, 0, 0, 0);
    run_op("negovf", 32'h7fff_ffff, 32'hffff_ffff,
           32'h8000_0000, 1, 1, 0);
    run_op("bp", 32'h1234_5678, 32'h0000_9abc,
           32'h1233_bbbc, 0, 0, 3);

    // Back-to-back with out_ready held high.
    nacc = 0;
    nres = 0;
    bus.in_valid  = 1'b1;
    bus.a = 32'h0000_0100;
    bus.b = 32'h0000_0001;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      logic took;
      took = 1'b0;
      if (bus.out_valid && nres < 2) begin
        res[nres] = bus.diff;
        nres++;
      end
      if (bus.in_valid && bus.in_ready && nacc < 2) begin
        acc[nacc] = cyc;
        nacc++;
        took = 1'b1;
      end
      tick();
      if (took && nacc == 1) begin
        bus.a = 32'h0000_0000;
        bus.b = 32'h0000_0002;
      end else if (took) begin
        bus.in_valid = 1'b0;
      end
      if (nres == 2) break;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("b2b.nacc", nacc, 2);
    check("b2b.nres", nres, 2);
    if (nacc == 2)
      check("b2b.spacing", acc[1] - acc[0], 6);
    if (nres == 2) begin
      check("b2b.res0", res[0], 32'h0000_00ff);
      check("b2b.res1", res[1], 32'hffff_fffe);
    end
    tick();
    check_idle("b2b.end");

    // Reset during the second BUSY cycle.
    bus.a = 32'h0000_0009;
    bus.b = 32'h0000_0004;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rstmid");
    check("rstmid.diff", bus.diff, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("rstmid.noresult", seen, 0);
    check("rstmid.inrdy", 32'(bus.in_ready), 1);

    run_op("post", 32'h0, 32'h1,
           32'hffff_ffff, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
